// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake status.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Arbiter FSM encoding and the default RAM-access timeout.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DREQ,
        IREQ,
        DRESP,
        IRESP
    } arb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request signals and RAM-side strobes shared by the arbiter and its environment.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      fault;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, fault
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, fault
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data requests, with
// alternation under contention, a wait-cycle timeout and RAM error abort.
module mem_arbiter
    import cpu_types_pkg::*, mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic           CLK,
    input  logic           nRST,
    mem_arbiter_if.slave   bus
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    arb_state_t state;
    logic       last_d;
    logic [7:0] wait_cnt;
    word_t      iload_q;
    word_t      dload_q;
    logic       fault_q;

    logic d_req;
    logic req_held;

    assign d_req    = bus.dREN | bus.dWEN;
    assign req_held = (state == DREQ) ? d_req : bus.iREN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            wait_cnt <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Data has priority unless it was served last and fetch is also waiting.
                    if (d_req && !(bus.iREN && last_d))
                        state <= DREQ;
                    else if (bus.iREN)
                        state <= IREQ;
                end
                DREQ, IREQ: begin
                    if (!req_held) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (bus.ramstate == ACCESS) begin
                        // ACCESS is checked before the timeout so it wins on the boundary cycle.
                        wait_cnt <= '0;
                        if (state == DREQ) begin
                            dload_q <= bus.ramload;
                            state   <= DRESP;
                        end else begin
                            iload_q <= bus.ramload;
                            state   <= IRESP;
                        end
                    end else if (bus.ramstate == ERROR || wait_cnt == TIMEOUT_W) begin
                        fault_q  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DRESP: begin
                    last_d <= 1'b1;
                    state  <= IDLE;
                end
                IRESP: begin
                    last_d <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            DREQ: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            IREQ: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
            end
            default: ;
        endcase
    end

    assign bus.dhit  = (state == DRESP);
    assign bus.ihit  = (state == IRESP);
    assign bus.iload = iload_q;
    assign bus.dload = dload_q;
    assign bus.fault = fault_q;

endmodule
